// File: rtl/adder_sched_pkg.sv
// Shared types and defaults for the two-requester adder scheduler.
//   N_REQ     : number of requesters sharing the adder
//   DEF_WIDTH : default operand width (sums are one bit wider)
//   DEF_LAT   : default adder latency in register stages
//   req_id_t  : requester index
//   tag_t     : in-flight tag {valid, id}
package adder_sched_pkg;

  localparam int unsigned N_REQ     = 2;
  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_LAT   = 2;

  typedef logic [0:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/adder_pipe_sched_rr_arbiter2.sv
// Two-way round-robin arbiter.
//   clk, rst_n : clock, synchronous active-low reset
//   req_i      : request vector (bit i = requester i)
//   gnt_o      : one-hot grant, combinational from req_i and the pointer
// The pointer remembers the last winner; on contention the other requester
// wins. Reset leaves the pointer on requester 1 so requester 0 wins first.
module rr_arbiter2
  import adder_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  req_id_t last_q;

  always_comb begin
    gnt_o = '0;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_q == 1'b1) ? 2'b01 : 2'b10;
      default: gnt_o = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (gnt_o[1]) begin
      last_q <= 1'b1;
    end else if (gnt_o[0]) begin
      last_q <= 1'b0;
    end
  end

endmodule

// File: rtl/adder_pipe_sched.sv
// Scheduler sharing one fixed-latency pipelined adder between two requesters.
//   req{0,1}_valid/ready/a/b : operation request, one outstanding op each
//   rsp{0,1}_valid/ready/result : 1-entry response buffer per requester
//   flush_req  : abort every in-flight op (buffered responses survive)
//   drop_mask  : 1-cycle pulse, bit i = requester i lost an in-flight op
//   pipe_a/b   : registered operands to the adder
//   pipe_flush : adder flush (also held during reset)
//   pipe_result: adder sum, LAT edges after pipe_a/pipe_b
//   busy       : any op in flight
module adder_pipe_sched
  import adder_sched_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned LAT   = DEF_LAT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH:0]   rsp0_result,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH:0]   rsp1_result,
  input  logic             flush_req,
  output logic [1:0]       drop_mask,
  output logic [WIDTH-1:0] pipe_a,
  output logic [WIDTH-1:0] pipe_b,
  output logic             pipe_flush,
  input  logic [WIDTH:0]   pipe_result,
  output logic             busy
);

  // Stage 0 travels alongside pipe_a/pipe_b; stage LAT lines up with pipe_result.
  tag_t             tag_q [LAT+1];
  logic [N_REQ-1:0] out_q, out_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [WIDTH:0]   rsp_result_q [N_REQ];
  logic [N_REQ-1:0] drop_q, drop_d;
  logic [WIDTH-1:0] pipe_a_q, pipe_b_q;

  logic [N_REQ-1:0] req_valid, req_ready, rsp_ready, cand, gnt, hs;
  logic             capture;
  req_id_t          cap_id;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};
  assign req_ready = ~out_q & {N_REQ{~flush_req & rst_n}};
  assign cand      = req_valid & req_ready;
  assign hs        = rsp_valid_q & rsp_ready;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (cand),
    .gnt_o (gnt)
  );

  always_comb begin
    drop_d      = '0;
    busy        = 1'b0;
    for (int unsigned k = 0; k <= LAT; k++) begin
      busy = busy | tag_q[k].valid;
      if (flush_req && tag_q[k].valid) begin
        drop_d[tag_q[k].id] = 1'b1;
      end
    end
    // A tag leaving the last stage on a flush edge is dropped, not captured.
    capture     = tag_q[LAT].valid & ~flush_req;
    cap_id      = tag_q[LAT].id;
    out_d       = (out_q | gnt) & ~hs & ~drop_d;
    rsp_valid_d = rsp_valid_q & ~hs;
    if (capture) begin
      rsp_valid_d[cap_id] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k <= LAT; k++) begin
        tag_q[k] <= '0;
      end
      for (int unsigned i = 0; i < N_REQ; i++) begin
        rsp_result_q[i] <= '0;
      end
      out_q       <= '0;
      rsp_valid_q <= '0;
      drop_q      <= '0;
      pipe_a_q    <= '0;
      pipe_b_q    <= '0;
    end else begin
      // gnt is already zero on a flush edge because ready is held low.
      tag_q[0] <= {|gnt, gnt[1]};
      for (int unsigned k = 1; k <= LAT; k++) begin
        tag_q[k] <= flush_req ? '0 : tag_q[k-1];
      end
      pipe_a_q    <= gnt[1] ? req1_a : (gnt[0] ? req0_a : '0);
      pipe_b_q    <= gnt[1] ? req1_b : (gnt[0] ? req0_b : '0);
      out_q       <= out_d;
      rsp_valid_q <= rsp_valid_d;
      drop_q      <= drop_d;
      if (capture) begin
        rsp_result_q[cap_id] <= pipe_result;
      end
    end
  end

  assign req0_ready  = req_ready[0];
  assign req1_ready  = req_ready[1];
  assign rsp0_valid  = rsp_valid_q[0];
  assign rsp1_valid  = rsp_valid_q[1];
  assign rsp0_result = rsp_result_q[0];
  assign rsp1_result = rsp_result_q[1];
  assign drop_mask   = drop_q;
  assign pipe_a      = pipe_a_q;
  assign pipe_b      = pipe_b_q;
  assign pipe_flush  = flush_req | ~rst_n;

endmodule

// File: tb/tb_adder_pipe_sched.sv
// Bench for adder_pipe_sched: a LAT-stage zero-extending adder sits on the
// pipe interface; a transaction-level model (in-flight queue with countdowns,
// per-requester outstanding/buffer state, last-winner pointer) predicts every
// output each cycle.
module tb_adder_pipe_sched;

  localparam int unsigned W = 8;
  localparam int unsigned L = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [W:0]   rsp0_result, rsp1_result;
  logic         flush_req;
  logic [1:0]   drop_mask;
  logic [W-1:0] pipe_a, pipe_b;
  logic         pipe_flush;
  logic [W:0]   pipe_result;
  logic         busy;

  always #5 clk = ~clk;

  adder_pipe_sched #(.WIDTH(W), .LAT(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .flush_req(flush_req), .drop_mask(drop_mask),
    .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_flush(pipe_flush),
    .pipe_result(pipe_result), .busy(busy)
  );

  // Environment adder: L register stages, zero-extending.
  logic [W:0] add_st [L];
  always @(posedge clk) begin
    add_st[0] <= {1'b0, pipe_a} + {1'b0, pipe_b};
    for (int k = 1; k < L; k++) add_st[k] <= add_st[k-1];
  end
  assign pipe_result = add_st[L-1];

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct {
    int         id;
    logic [W:0] sum;
    int         cnt;
  } op_t;
  op_t        inflight[$];
  bit         m_known = 0;
  bit         m_out [2];
  bit         m_bv  [2];
  logic [W:0] m_bres[2];
  int         m_last;
  logic [1:0] m_drop;
  logic [W-1:0] m_pa, m_pb;

  task automatic step(input bit rst, input bit v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                      input bit v1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                      input bit fl, input bit r0, input bit r1);
    bit  er [2];
    bit  v  [2];
    bit  r  [2];
    logic [W-1:0] aa [2];
    logic [W-1:0] bb [2];
    int  win;
    op_t keep[$];
    @(negedge clk);
    rst_n = rst; flush_req = fl;
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    rsp0_ready = r0; rsp1_ready = r1;
    #1;
    v[0] = v0; v[1] = v1; r[0] = r0; r[1] = r1;
    aa[0] = a0; aa[1] = a1; bb[0] = b0; bb[1] = b1;
    for (int i = 0; i < 2; i++) er[i] = rst && !m_out[i] && !fl;
    check("pipe_flush", pipe_flush, fl | !rst);
    if (m_known) begin
      check("req0_ready", req0_ready, er[0]);
      check("req1_ready", req1_ready, er[1]);
      check("rsp0_valid", rsp0_valid, m_bv[0]);
      check("rsp1_valid", rsp1_valid, m_bv[1]);
      if (m_bv[0]) check("rsp0_result", rsp0_result, m_bres[0]);
      if (m_bv[1]) check("rsp1_result", rsp1_result, m_bres[1]);
      check("busy", busy, inflight.size() != 0);
      check("drop_mask", drop_mask, m_drop);
      check("pipe_a", pipe_a, m_pa);
      check("pipe_b", pipe_b, m_pb);
    end
    // Advance the model across the coming edge.
    if (!rst) begin
      inflight.delete();
      for (int i = 0; i < 2; i++) begin
        m_out[i] = 0; m_bv[i] = 0; m_bres[i] = '0;
      end
      m_last = 1; m_drop = '0; m_pa = '0; m_pb = '0; m_known = 1;
    end else begin
      for (int i = 0; i < 2; i++)
        if (m_bv[i] && r[i]) begin m_bv[i] = 0; m_out[i] = 0; end
      m_drop = '0; m_pa = '0; m_pb = '0;
      if (fl) begin
        foreach (inflight[j]) begin
          m_drop[inflight[j].id] = 1'b1;
          m_out[inflight[j].id]  = 0;
        end
        inflight.delete();
      end else begin
        keep.delete();
        foreach (inflight[j]) begin
          op_t o;
          o = inflight[j];
          o.cnt--;
          if (o.cnt == 0) begin
            m_bv[o.id] = 1; m_bres[o.id] = o.sum;
          end else keep.push_back(o);
        end
        inflight = keep;
        win = -1;
        if (v[0] && er[0] && v[1] && er[1]) win = (m_last == 0) ? 1 : 0;
        else if (v[0] && er[0])             win = 0;
        else if (v[1] && er[1])             win = 1;
        if (win >= 0) begin
          op_t o;
          o.id  = win;
          o.sum = {1'b0, aa[win]} + {1'b0, bb[win]};
          o.cnt = L + 1;
          inflight.push_back(o);
          m_out[win] = 1; m_last = win;
          m_pa = aa[win]; m_pb = bb[win];
        end
      end
    end
  endtask

  task automatic idle(input int n, input bit r0, input bit r1);
    for (int i = 0; i < n; i++) step(1, 0, '0, '0, 0, '0, '0, 0, r0, r1);
  endtask

  initial begin
    // Reset
    for (int i = 0; i < 3; i++) step(0, 0, '0, '0, 0, '0, '0, 0, 1, 1);
    idle(1, 1, 1);
    // Single op and carry-out
    step(1, 1, 8'h03, 8'h02, 0, '0, '0, 0, 1, 1);
    idle(5, 1, 1);
    step(1, 0, '0, '0, 1, 8'hFF, 8'h01, 0, 1, 1);
    idle(5, 1, 1);
    // Contention twice
    step(1, 1, 8'h10, 8'h20, 1, 8'h01, 8'h01, 0, 1, 1);
    step(1, 0, '0, '0, 1, 8'h01, 8'h01, 0, 1, 1);
    idle(6, 1, 1);
    step(1, 1, 8'h44, 8'h55, 1, 8'h66, 8'h77, 0, 1, 1);
    step(1, 0, '0, '0, 1, 8'h66, 8'h77, 0, 1, 1);
    idle(6, 1, 1);
    // Flush mid-flight, and flush against a tag at the last stage
    step(1, 0, '0, '0, 1, 8'h03, 8'h04, 0, 1, 1);
    step(1, 0, '0, '0, 0, '0, '0, 1, 1, 1);
    idle(6, 1, 1);
    step(1, 1, 8'h09, 8'h09, 0, '0, '0, 0, 1, 1);
    idle(L, 1, 1);
    step(1, 0, '0, '0, 0, '0, '0, 1, 1, 1);
    idle(5, 1, 1);
    // Backpressure on rsp0 while req1 keeps working
    step(1, 1, 8'hA0, 8'h0B, 0, '0, '0, 0, 0, 1);
    idle(3, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 1, 8'h11, 8'h22, 1, 8'(i), 8'h80, 0, 0, 1);
    idle(4, 0, 1);
    idle(4, 1, 1);
    // Reset mid-operation
    step(1, 1, 8'h01, 8'h02, 1, 8'h03, 8'h04, 0, 1, 1);
    step(0, 0, '0, '0, 0, '0, '0, 0, 1, 1);
    idle(4, 1, 1);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 499) != 0),
           ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
           ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
           ($urandom_range(0, 14) == 0),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
    end
    idle(6, 1, 1);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
